// File: rtl/fft_out_streamer_pkg.sv
// fft_out_streamer shared types.
// Streamer FSM states and default frame geometry.
package fft_out_streamer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_N   = 16;
  localparam int DEF_MSB = 16;

endpackage

// File: rtl/fft_out_streamer_if.sv
// fft_out_streamer output stream bundle.
// Bin word, magnitude and index under valid/ready.
interface fft_out_streamer_if #(
  parameter int N   = 16,
  parameter int MSB = 16
);
  localparam int IW = $clog2(N);

  logic           o_valid;
  logic           o_ready;
  logic [MSB-1:0] o_data;
  logic [MSB:0]   o_mag;
  logic [IW-1:0]  o_idx;
  logic           o_last;

  modport master (
    output o_valid, o_data, o_mag, o_idx, o_last,
    input  o_ready
  );

  modport slave (
    input  o_valid, o_data, o_mag, o_idx, o_last,
    output o_ready
  );
endinterface

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: squared magnitude of one complex bin.
// Upper half signed real, lower half signed imag.
module fft_mag_sq #(
  parameter int MSB = 16
) (
  input  logic [MSB-1:0] word_i,
  output logic [MSB:0]   mag_o
);
  localparam int H = MSB / 2;

  logic signed [MSB-1:0] re;
  logic signed [MSB-1:0] im;
  logic signed [MSB-1:0] re2;
  logic signed [MSB-1:0] im2;

  assign re  = {{H{word_i[MSB-1]}}, word_i[MSB-1:H]};
  assign im  = {{H{word_i[H-1]}}, word_i[H-1:0]};
  assign re2 = re * re;
  assign im2 = im * im;

  // Each square is non-negative, so the sum fits MSB+1 bits.
  assign mag_o = {1'b0, re2} + {1'b0, im2};
endmodule

// File: rtl/fft_out_streamer.sv
// fft_out_streamer: captures an FFT frame on calc_finish
// and streams bins with squared magnitude under valid/ready.
module fft_out_streamer
  import fft_out_streamer_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int MSB = DEF_MSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*MSB-1:0] fft_data_in,
  input  logic             calc_finish,
  input  logic             clr_overrun,
  fft_out_streamer_if.master os,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);
  localparam int IW = $clog2(N);

  state_e           state_q, state_d;
  logic [N*MSB-1:0] buf_q, buf_d;
  logic [MSB-1:0]   data_q, data_d;
  logic [MSB:0]     mag_q, mag_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    nxt;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             xfer;
  logic             at_end;

  assign xfer   = valid_q && os.o_ready;
  assign at_end = idx_q == IW'(N - 1);
  assign nxt    = idx_q + IW'(1);

  fft_mag_sq #(.MSB(MSB)) u_mag (
    .word_i (data_d),
    .mag_o  (mag_d)
  );

  // Next state: capture, advance, finish, drop detection.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (calc_finish) begin
          buf_d   = fft_data_in;
          data_d  = fft_data_in[MSB-1:0];
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && !at_end) begin
          idx_d  = nxt;
          data_d = buf_q[nxt*MSB +: MSB];
        end
        if (xfer && at_end) begin
          done_d = 1'b1;
          if (calc_finish) begin
            buf_d  = fft_data_in;
            data_d = fft_data_in[MSB-1:0];
            idx_d  = '0;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        // A frame arriving mid-stream is dropped; set beats clear.
        if (calc_finish && !(xfer && at_end)) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mag_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mag_q   <= mag_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame buffer: contents are irrelevant until captured.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign os.o_valid = valid_q;
  assign os.o_data  = data_q;
  assign os.o_mag   = mag_q;
  assign os.o_idx   = idx_q;
  assign os.o_last  = valid_q && at_end;
  assign busy       = state_q == SEND;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_fft_out_streamer.sv
// tb_fft_out_streamer: scoreboard plus vector table
// bench for the FFT output streamer.
module tb_fft_out_streamer;
  localparam int N   = 16;
  localparam int MSB = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N*MSB-1:0] bus = '0;
  logic             calc_finish = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             busy, frame_done, overrun;

  fft_out_streamer_if #(.N(N), .MSB(MSB)) ifc ();

  fft_out_streamer #(.N(N), .MSB(MSB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft_data_in (bus),
    .calc_finish (calc_finish),
    .clr_overrun (clr_overrun),
    .os          (ifc),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          mag;
    int          idx;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    int          mag;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[16];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  task automatic chk(string nm, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic int mag_of(logic [15:0] w);
    int re, im;
    re = int'($signed(w[15:8]));
    im = int'($signed(w[7:0]));
    return re * re + im * im;
  endfunction

  task automatic push_frame(input logic [N*MSB-1:0] b);
    exp_t x;
    for (int k = 0; k < N; k++) begin
      x.data = b[k*MSB +: MSB];
      x.mag  = mag_of(x.data);
      x.idx  = k;
      sb.push_back(x);
    end
  endtask

  // Monitor: transfers, stall stability, frame_done timing.
  logic [15:0] pd;
  logic [16:0] pm;
  logic [3:0]  pi;
  bit          pstall = 0;
  bit          pend = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pstall = 0;
      pend = 0;
    end else begin
      chk("frame_done", frame_done, pend);
      if (frame_done) done_cnt++;
      pend = 0;
      if (pstall) begin
        chk("stall_valid", ifc.o_valid, 1);
        chk("stall_data", ifc.o_data, pd);
        chk("stall_mag", ifc.o_mag, pm);
        chk("stall_idx", ifc.o_idx, pi);
      end
      if (ifc.o_valid && ifc.o_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: idx %0d data %h, queue empty",
                   ifc.o_idx, ifc.o_data);
        end else begin
          e = sb.pop_front();
          chk("xfer_data", ifc.o_data, e.data);
          chk("xfer_mag", ifc.o_mag, e.mag);
          chk("xfer_idx", ifc.o_idx, e.idx);
          chk("xfer_last", ifc.o_last, e.idx == N - 1);
          pend = (e.idx == N - 1);
        end
      end
      pstall = ifc.o_valid && !ifc.o_ready;
      pd = ifc.o_data;
      pm = ifc.o_mag;
      pi = ifc.o_idx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N*MSB-1:0] b);
    bus = b;
    calc_finish = 1'b1;
    push_frame(b);
    step();
    calc_finish = 1'b0;
  endtask

  task automatic drain(string nm, input bit bp);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      ifc.o_ready = bp ? (n % 3 == 0) : 1'b1;
      step();
      n++;
    end
    ifc.o_ready = 1'b1;
    step();
    step();
    chk({nm, "_left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_idx(int k);
    int n = 0;
    while (!(ifc.o_valid && ifc.o_idx == 4'(k)) && n < 100) begin
      step();
      n++;
    end
    chk("wait_idx_timeout", n < 100, 1);
  endtask

  function automatic logic [N*MSB-1:0] rnd_frame();
    logic [N*MSB-1:0] b;
    for (int k = 0; k < N; k++) b[k*MSB +: MSB] = 16'($urandom);
    return b;
  endfunction

  logic [N*MSB-1:0] fa, fb;
  int               d0;

  initial begin
    tbl[0]  = '{16'h0000, 0};
    tbl[1]  = '{16'h03FD, 18};
    tbl[2]  = '{16'h7F80, 32513};
    tbl[3]  = '{16'h8080, 32768};
    tbl[4]  = '{16'hFFFF, 2};
    tbl[5]  = '{16'h7F7F, 32258};
    tbl[6]  = '{16'h0100, 1};
    tbl[7]  = '{16'h0001, 1};
    tbl[8]  = '{16'h8000, 16384};
    tbl[9]  = '{16'h0080, 16384};
    tbl[10] = '{16'h7F00, 16129};
    tbl[11] = '{16'h007F, 16129};
    tbl[12] = '{16'h0505, 50};
    tbl[13] = '{16'hFB05, 50};
    tbl[14] = '{16'h1020, 1280};
    tbl[15] = '{16'hC0C0, 8192};

    // Reset, with calc_finish ignored while held.
    ifc.o_ready = 1'b1;
    rst_n = 1'b0;
    calc_finish = 1'b1;
    repeat (3) step();
    calc_finish = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("rst_valid", ifc.o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", ifc.o_data, 0);
    chk("rst_mag", ifc.o_mag, 0);
    chk("rst_idx", ifc.o_idx, 0);
    chk("rst_last", ifc.o_last, 0);
    chk("rst_done", frame_done, 0);

    // Single frame at full throughput.
    for (int k = 0; k < N; k++) fa[k*MSB +: MSB] = {8'(k), 8'(-k)};
    chk("pre_valid", ifc.o_valid, 0);
    pulse(fa);
    chk("lat_busy", busy, 1);
    chk("lat_idx", ifc.o_idx, 0);
    for (int i = 0; i < N; i++) begin
      chk("stream_valid", ifc.o_valid, 1);
      if (i == 3) begin
        chk("bin3_data", ifc.o_data, 16'h03FD);
        chk("bin3_mag", ifc.o_mag, 18);
      end
      step();
    end
    chk("end_done", frame_done, 1);
    chk("end_valid", ifc.o_valid, 0);
    step();
    chk("end_busy", busy, 0);
    chk("end_done_once", frame_done, 0);
    drain("single", 0);

    // Backpressure with a random frame, bin 5 = 7F80.
    fa = rnd_frame();
    fa[5*MSB +: MSB] = 16'h7F80;
    pulse(fa);
    drain("bp", 1);

    // Vector table: boundary magnitudes, cycle-exact.
    for (int k = 0; k < N; k++) fa[k*MSB +: MSB] = tbl[k].w;
    pulse(fa);
    for (int i = 0; i < N; i++) begin
      chk("tbl_idx", ifc.o_idx, i);
      chk("tbl_data", ifc.o_data, tbl[i].w);
      chk("tbl_mag", ifc.o_mag, tbl[i].mag);
      step();
    end
    drain("tbl", 0);

    // Overrun: drop at idx 7, set-beats-clear, then clear.
    fa = rnd_frame();
    pulse(fa);
    wait_idx(7);
    bus = ~fa;
    calc_finish = 1'b1;
    step();
    calc_finish = 1'b0;
    chk("ovr_set", overrun, 1);
    calc_finish = 1'b1;
    clr_overrun = 1'b1;
    step();
    calc_finish = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", overrun, 0);
    drain("ovr", 0);

    // Back-to-back frames.
    fa = rnd_frame();
    fb = rnd_frame();
    pulse(fa);
    wait_idx(15);
    pulse(fb);
    chk("b2b_done", frame_done, 1);
    chk("b2b_valid", ifc.o_valid, 1);
    chk("b2b_idx", ifc.o_idx, 0);
    chk("b2b_data", ifc.o_data, fb[MSB-1:0]);
    chk("b2b_ovr", overrun, 0);
    drain("b2b", 0);

    // Reset mid-stream.
    fa = rnd_frame();
    pulse(fa);
    wait_idx(9);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", ifc.o_valid, 0);
    chk("mrst_busy", busy, 0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("mrst_no_done", done_cnt, d0);
    chk("mrst_idle", ifc.o_valid, 0);
    fb = rnd_frame();
    pulse(fb);
    chk("mrst_idx0", ifc.o_idx, 0);
    chk("mrst_data0", ifc.o_data, fb[MSB-1:0]);
    drain("mrst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_out_streamer.md
Name: fft_out_streamer

Overview:
- Downstream consumer of the FFT stage's flat result bus.
- On the calc-finish pulse it captures all N complex bins into a frame buffer.
- It then streams the bins out one per handshake, in index order, with valid/ready flow control.
- Alongside each raw bin word it emits the bin's squared magnitude, so the magnitude/readout logic never touches the wide bus.

Parameters:
- N, 16, number of FFT bins per frame (power of two, ≥4).
- MSB, 16, bits per bin word: upper MSB/2 bits are signed real, lower MSB/2 bits are signed imaginary (two's complement).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fft_data_in  in  N*MSB  result bus; bin k = fft_data_in[k*MSB +: MSB].
- calc_finish  in  1  single-cycle pulse: fft_data_in valid this cycle.
- o_ready  in  1  sink ready.
- clr_overrun  in  1  synchronous clear of the overrun flag.
- o_valid  out  1  o_data/o_mag/o_idx/o_last valid.
- o_data  out  MSB  raw bin word.
- o_mag  out  MSB+1  re*re + im*im, unsigned.
- o_idx  out  log2(N)  bin index of current output.
- o_last  out  1  current output is bin N-1.
- busy  out  1  a frame is held or streaming.
- frame_done  out  1  one-cycle pulse after the bin N-1 handshake.
- overrun  out  1  sticky: a calc_finish was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - o_valid, o_last, busy, frame_done, overrun = 0.
  - o_data, o_mag, o_idx = 0.
  - Frame buffer contents are don't-care.
- Handshake:
  - A transfer occurs on a cycle with o_valid=1 and o_ready=1.
  - While o_valid=1 and o_ready=0, all outputs hold stable.
  - o_valid never drops without a transfer, except on reset.
- FSM states: IDLE, SEND.
- IDLE:
  - On calc_finish=1: latch the whole bus into the buffer, load output registers with bin 0, set o_idx=0 and o_valid=1, and go to SEND.
  - Latency: o_valid rises the cycle after calc_finish.
- SEND, on transfer with o_idx<N-1: load the output registers with bin o_idx+1 the next cycle; o_valid stays 1, giving full throughput at one bin per cycle.
- SEND, on transfer with o_idx==N-1:
  - frame_done=1 the next cycle (one cycle only).
  - If calc_finish is also 1 that cycle: capture the new frame, present bin 0 next cycle, stay in SEND. This is back-to-back and not an overrun.
  - Otherwise: o_valid=0, go to IDLE.
- calc_finish in SEND, other than the last-transfer cycle:
  - The frame is discarded and the buffer is untouched.
  - overrun=1 next cycle.
  - The current stream continues unaffected.
- overrun:
  - Cleared by clr_overrun=1 the next cycle.
  - If clr_overrun and a new drop occur in the same cycle, the set wins.
- o_last = o_valid && (o_idx==N-1).
- busy = 1 in SEND, 0 in IDLE.
- o_mag arithmetic:
  - re and im are sign-extended, squared as signed MSB-bit products, and summed as unsigned MSB+1 bits.
  - Maximum is 2*(2^(MSB/2-1))^2 = 2^(MSB-1), so it never overflows MSB+1 bits.
  - o_mag is registered with o_data: same cycle, no extra latency.
- Reset mid-stream: the frame is abandoned, there is no frame_done, and after release the block waits for the next calc_finish.
- calc_finish while rst_n=0: ignored.

Decomposition:
- No shared package needed; the index width is derived locally as $clog2(N).
- One natural sub-module: fft_mag_sq.
  - Combinational: input MSB-bit bin word, output MSB+1-bit squared magnitude.
  - Reusable by later magnitude/peak-detect blocks.
- Frame buffer is a flat N*MSB register, indexed by part-select on o_idx.

Test Plan (N=16, MSB=16):
- Reset then idle: rst_n low, then high, no calc_finish for 20 cycles -> o_valid=0, busy=0, overrun=0, all data outputs 0.
- Single frame, o_ready=1: bin k = {8'(k), 8'(-k)}, calc_finish pulse -> o_valid from the next cycle for 16 consecutive cycles; o_idx 0..15; bin 3 o_data=16'h03FD, o_mag=18; o_last only at idx 15; frame_done one cycle later; busy back to 0.
- Backpressure: o_ready toggles 1,0,0,1,...; bin 5=16'h7F80 (re=127, im=-128) -> outputs stable while stalled; bin 5 o_mag=32513; all 16 bins delivered in order with no loss or duplication.
- Overrun: second calc_finish at idx 7 with different data -> stream still delivers the first frame's bins 8..15; overrun=1 next cycle; clr_overrun pulse -> overrun=0.
- Back-to-back: calc_finish in the same cycle as the idx-15 transfer -> frame_done=1 and o_valid=1 with new bin 0 next cycle; overrun stays 0.
- Reset mid-stream: rst_n low at idx 9 -> o_valid=0 immediately (async); no frame_done after release; next calc_finish streams from bin 0.
